// File: rtl/accum_stream_pkg.sv
// Shared constants for the accumulator result streamer: FSM encodings,
// default frame length and skid FIFO depth.
package accum_stream_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_DRAIN  = 2'd2;

    localparam int unsigned NUMBER_OF_WORDS_DEFAULT = 1024;
    localparam int unsigned SKID_DEPTH              = 2;

endpackage

// File: rtl/accum_result_streamer_if.sv
// AXI4-Stream bundle carrying result words out of the streamer.
interface accum_result_streamer_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                      TVALID;
    logic                      TREADY;
    logic [DATA_WIDTH-1:0]     TDATA;
    logic [DATA_WIDTH/8-1:0]   TSTRB;
    logic                      TLAST;

    modport master (output TVALID, output TDATA, output TSTRB, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TSTRB, input TLAST, output TREADY);
endinterface

// File: rtl/result_skid_buffer.sv
// Two-entry FIFO that absorbs BRAM read data in flight while the stream stalls.
module result_skid_buffer
    import accum_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       occupancy_o
);
    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != 2'd0);
        do_push = push_i && ((count_q != 2'(SKID_DEPTH)) || do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign data_o      = mem_q[rd_ptr_q];
    assign occupancy_o = count_q;
endmodule

// File: rtl/accum_result_streamer.sv
// Streams one frame of result BRAM words out over AXI4-Stream per FRAME_READY,
// with a one-deep pending notification and a sticky overrun flag.
module accum_result_streamer
    import accum_stream_pkg::*;
#(
    parameter int unsigned BRAM_DEPTH          = 10,
    parameter int unsigned RES_BRAM_DATA_WIDTH = 64,
    parameter int unsigned NUMBER_OF_WORDS     = NUMBER_OF_WORDS_DEFAULT
) (
    input  logic                           M_AXIS_ACLK,
    input  logic                           M_AXIS_ARESET,
    input  logic                           FRAME_READY,
    output logic [BRAM_DEPTH-1:0]          RESULT_BRAM_ADDR_READ,
    output logic                           RESULT_BRAM_RENABLE,
    input  logic [RES_BRAM_DATA_WIDTH-1:0] RESULT_BRAM_DATAIN,
    accum_result_streamer_if.master        m_axis,
    output logic                           OVERRUN,
    output logic [15:0]                    FRAMES_SENT,
    output logic                           BUSY
);
    localparam logic [BRAM_DEPTH-1:0] LAST_ADDR = BRAM_DEPTH'(NUMBER_OF_WORDS - 1);

    state_t                    state_q, state_d;
    logic [BRAM_DEPTH-1:0]     rd_cnt_q, rd_cnt_d;
    logic [BRAM_DEPTH-1:0]     addr_q, addr_d;
    logic                      inflight_q, inflight_d;
    logic                      inflight_last_q, inflight_last_d;
    logic                      pending_q, pending_d;
    logic                      overrun_q, overrun_d;
    logic [15:0]               frames_q, frames_d;

    logic [RES_BRAM_DATA_WIDTH:0] fifo_dout;
    logic [1:0]                   occ;
    logic                         tvalid;
    logic                         pop;
    logic                         last_pop;
    logic                         issue;
    logic [2:0]                   load;

    always_comb begin
        tvalid   = (occ != 2'd0);
        pop      = tvalid && m_axis.TREADY;
        last_pop = pop && fifo_dout[RES_BRAM_DATA_WIDTH];
        // Count the word still in flight from last cycle so the FIFO can never overflow.
        load     = 3'(occ) + 3'(inflight_q) - 3'(pop);
        issue    = (state_q == ST_STREAM) && (load < 3'(SKID_DEPTH));

        state_d         = state_q;
        rd_cnt_d        = rd_cnt_q;
        addr_d          = addr_q;
        pending_d       = pending_q;
        overrun_d       = overrun_q;
        inflight_d      = issue;
        inflight_last_d = issue && (rd_cnt_q == LAST_ADDR);
        frames_d        = frames_q + 16'(last_pop);

        if (issue) begin
            addr_d   = rd_cnt_q;
            rd_cnt_d = rd_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (FRAME_READY || pending_q) begin
                    state_d   = ST_STREAM;
                    rd_cnt_d  = '0;
                    pending_d = pending_q && FRAME_READY;
                end
            end
            ST_STREAM: begin
                if (issue && (rd_cnt_q == LAST_ADDR)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_pop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && FRAME_READY) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            state_q         <= ST_IDLE;
            rd_cnt_q        <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            pending_q       <= 1'b0;
            overrun_q       <= 1'b0;
            frames_q        <= '0;
        end else begin
            state_q         <= state_d;
            rd_cnt_q        <= rd_cnt_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            pending_q       <= pending_d;
            overrun_q       <= overrun_d;
            frames_q        <= frames_d;
        end
    end

    result_skid_buffer #(
        .WIDTH(RES_BRAM_DATA_WIDTH + 1)
    ) u_skid (
        .clk_i       (M_AXIS_ACLK),
        .rst_i       (M_AXIS_ARESET),
        .push_i      (inflight_q),
        .pop_i       (pop),
        .data_i      ({inflight_last_q, RESULT_BRAM_DATAIN}),
        .data_o      (fifo_dout),
        .occupancy_o (occ)
    );

    assign RESULT_BRAM_RENABLE   = issue;
    assign RESULT_BRAM_ADDR_READ = issue ? rd_cnt_q : addr_q;

    assign m_axis.TVALID = tvalid;
    assign m_axis.TDATA  = fifo_dout[RES_BRAM_DATA_WIDTH-1:0];
    assign m_axis.TLAST  = fifo_dout[RES_BRAM_DATA_WIDTH];
    assign m_axis.TSTRB  = '1;

    assign OVERRUN     = overrun_q;
    assign FRAMES_SENT = frames_q;
    assign BUSY        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_accum_result_streamer.sv
// Directed bench for accum_result_streamer: BRAM model returns word i at address i.
module tb_accum_result_streamer;
    localparam int DW = 64;
    localparam int AW = 10;
    localparam int NW = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fr  = 1'b0;
    logic [AW-1:0] addr;
    logic          ren;
    logic [DW-1:0] bram_q = '0;
    logic          overrun;
    logic [15:0]   frames;
    logic          busy;

    accum_result_streamer_if #(.DATA_WIDTH(DW)) axis ();

    accum_result_streamer #(
        .BRAM_DEPTH          (AW),
        .RES_BRAM_DATA_WIDTH (DW),
        .NUMBER_OF_WORDS     (NW)
    ) dut (
        .M_AXIS_ACLK           (clk),
        .M_AXIS_ARESET         (rst),
        .FRAME_READY           (fr),
        .RESULT_BRAM_ADDR_READ (addr),
        .RESULT_BRAM_RENABLE   (ren),
        .RESULT_BRAM_DATAIN    (bram_q),
        .m_axis                (axis),
        .OVERRUN               (overrun),
        .FRAMES_SENT           (frames),
        .BUSY                  (busy)
    );

    always #5 clk = ~clk;

    // Junk when no read was issued, so misaligned capture shows up as bad data.
    always @(posedge clk) bram_q <= ren ? {{(DW-AW){1'b0}}, addr} : 64'hDEAD_BEEF_0BAD_F00D;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, beats = 0, reads = 0, lasts = 0;
    int first_cyc = 0, last_cyc = 0;
    int exp_word = 0, exp_addr = 0;
    logic          stall_q = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic          hold_last = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs after the falling edge, then sample what the rising edge will see.
    task automatic step(input logic r, input logic f, input logic rdy);
        @(negedge clk);
        rst = r;
        fr  = f;
        axis.TREADY = rdy;
        #1;
        cyc++;
        if (r) begin
            beats = 0; reads = 0; lasts = 0;
            exp_word = 0; exp_addr = 0;
            stall_q = 1'b0;
        end else begin
            if (ren) begin
                check("rd_addr", 64'(addr), 64'(exp_addr));
                exp_addr = (exp_addr + 1) % NW;
                reads++;
            end
            if (stall_q) begin
                check("stall_valid", 64'(axis.TVALID), 64'd1);
                check("stall_data", axis.TDATA, hold_data);
                check("stall_last", 64'(axis.TLAST), 64'(hold_last));
            end
            if (axis.TVALID && rdy) begin
                check("beat_data", axis.TDATA, 64'(exp_word));
                check("beat_last", 64'(axis.TLAST), 64'(exp_word == NW - 1));
                if (axis.TLAST) lasts++;
                if (beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                beats++;
                exp_word = (exp_word + 1) % NW;
            end
            stall_q   = axis.TVALID && !rdy;
            hold_data = axis.TDATA;
            hold_last = axis.TLAST;
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic f;
        logic p2, p3;
        axis.TREADY = 1'b0;

        // Reset state
        do_reset();
        check("rst_tvalid", 64'(axis.TVALID), 64'd0);
        check("rst_tlast", 64'(axis.TLAST), 64'd0);
        check("rst_tdata", axis.TDATA, 64'd0);
        check("rst_ren", 64'(ren), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_frames", 64'(frames), 64'd0);
        check("rst_tstrb", 64'(axis.TSTRB), 64'hFF);

        // Full-rate frame with latency check
        step(1'b0, 1'b1, 1'b1);
        check("lat_c0_valid", 64'(axis.TVALID), 64'd0);
        step(1'b0, 1'b0, 1'b1);
        check("lat_c1_ren", 64'(ren), 64'd1);
        check("lat_c1_valid", 64'(axis.TVALID), 64'd0);
        check("lat_c1_busy", 64'(busy), 64'd1);
        step(1'b0, 1'b0, 1'b1);
        check("lat_c2_valid", 64'(axis.TVALID), 64'd0);
        step(1'b0, 1'b0, 1'b1);
        check("lat_c3_valid", 64'(axis.TVALID), 64'd1);
        for (int i = 0; i < 1100 && lasts == 0; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        check("full_beats", 64'(beats), 64'(NW));
        check("full_span", 64'(last_cyc - first_cyc), 64'(NW - 1));
        check("full_lasts", 64'(lasts), 64'd1);
        check("full_reads", 64'(reads), 64'(NW));
        check("full_frames", 64'(frames), 64'd1);
        check("full_idle", 64'(busy), 64'd0);

        // Random back-pressure
        do_reset();
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 6000 && lasts == 0; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        check("rnd_beats", 64'(beats), 64'(NW));
        check("rnd_lasts", 64'(lasts), 64'd1);
        check("rnd_reads", 64'(reads), 64'(NW));
        check("rnd_frames", 64'(frames), 64'd1);

        // Permanent stall: only two reads may be outstanding
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
        check("stall_reads", 64'(reads), 64'd2);
        check("stall_tvalid", 64'(axis.TVALID), 64'd1);
        check("stall_tdata", axis.TDATA, 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_frames", 64'(frames), 64'd0);

        // Pending frame at beat 500, overrun at beat 600
        do_reset();
        p2 = 1'b0; p3 = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3000 && lasts < 2; i++) begin
            f = 1'b0;
            if (beats == 500 && !p2) begin f = 1'b1; p2 = 1'b1; end
            if (beats == 600 && !p3) begin
                check("ovr_before", 64'(overrun), 64'd0);
                f = 1'b1; p3 = 1'b1;
            end
            step(1'b0, f, 1'b1);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_beats", 64'(beats), 64'(2 * NW));
        check("ovr_lasts", 64'(lasts), 64'd2);
        check("ovr_frames", 64'(frames), 64'd2);
        check("ovr_idle", 64'(busy), 64'd0);

        // Notification coinciding with the TLAST acceptance becomes pending
        do_reset();
        p2 = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3000 && lasts < 2; i++) begin
            f = 1'b0;
            if (beats == NW - 1 && !p2) begin f = 1'b1; p2 = 1'b1; end
            step(1'b0, f, 1'b1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        check("edge_overrun", 64'(overrun), 64'd0);
        check("edge_beats", 64'(beats), 64'(2 * NW));
        check("edge_frames", 64'(frames), 64'd2);

        // Reset mid-frame at beat 300, then a clean restart
        do_reset();
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 400 && beats < 300; i++) step(1'b0, 1'b0, 1'b1);
        check("mid_beats", 64'(beats), 64'd300);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("mid_tvalid", 64'(axis.TVALID), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_frames", 64'(frames), 64'd0);
        step(1'b0, 1'b0, 1'b1);
        check("mid_discard", 64'(axis.TVALID), 64'd0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 1100 && lasts == 0; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        check("restart_beats", 64'(beats), 64'(NW));
        check("restart_reads", 64'(reads), 64'(NW));
        check("restart_frames", 64'(frames), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/accum_result_streamer.md
ACCUM_RESULT_STREAMER -- requirements
Module: accum_result_streamer

Interface
REQ-001 SHALL have parameter BRAM_DEPTH, default 10; result BRAM address width.
REQ-002 SHALL have parameter RES_BRAM_DATA_WIDTH, default 64; result word width and stream TDATA width.
REQ-003 SHALL have parameter NUMBER_OF_WORDS, default 1024; words per frame.
REQ-004 SHALL have port M_AXIS_ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port M_AXIS_ARESET  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port FRAME_READY  in  1  one-cycle pulse: result BRAM holds a complete frame.
REQ-007 SHALL have port RESULT_BRAM_ADDR_READ  out  BRAM_DEPTH  read address.
REQ-008 SHALL have port RESULT_BRAM_RENABLE  out  1  read strobe.
REQ-009 SHALL have port RESULT_BRAM_DATAIN  in  RES_BRAM_DATA_WIDTH  read data, valid exactly 1 cycle after strobe.
REQ-010 SHALL have ports M_AXIS_TVALID out 1, M_AXIS_TREADY in 1, M_AXIS_TDATA out RES_BRAM_DATA_WIDTH, M_AXIS_TSTRB out RES_BRAM_DATA_WIDTH/8, M_AXIS_TLAST out 1; AXI4-Stream master.
REQ-011 SHALL have port OVERRUN  out  1  sticky: frame notification lost.
REQ-012 SHALL have port FRAMES_SENT  out  16  count of frames completed (TLAST accepted), wraps at 65535->0.
REQ-013 SHALL have port BUSY  out  1  high when state is not IDLE.

Function
REQ-014 SHALL use states IDLE, STREAM, DRAIN; IDLE->STREAM on FRAME_READY or pending flag; STREAM->DRAIN in the cycle after last address (NUMBER_OF_WORDS-1) is issued; DRAIN->IDLE when beat with TLAST is accepted (TVALID&TREADY).
REQ-015 SHALL issue reads at addresses 0..NUMBER_OF_WORDS-1 ascending, each exactly once per frame, only in STREAM.
REQ-016 SHALL buffer read data in a 2-entry skid FIFO; read issued in a cycle only when (occupancy + in-flight − pop_this_cycle) < 2.
REQ-017 SHALL sustain one beat per cycle while TREADY is held high.
REQ-018 SHALL assert first TVALID exactly 3 cycles after FRAME_READY cycle from IDLE (cycle 0 pulse, cycle 1 read addr 0, cycle 2 data, cycle 3 TVALID).
REQ-019 SHALL hold TDATA/TLAST stable and TVALID high while TVALID&!TREADY; TVALID never deasserts without acceptance.
REQ-020 SHALL drive TSTRB all ones; TLAST high only on the beat carrying word NUMBER_OF_WORDS-1.
REQ-021 SHALL, on FRAME_READY while BUSY, set a one-deep pending flag; the pending frame starts in the cycle after DRAIN->IDLE.
REQ-022 SHALL, on FRAME_READY while pending flag already set, set OVERRUN and discard the notification; FRAME_READY in same cycle as DRAIN->IDLE sets pending, not OVERRUN.
REQ-023 SHALL clear OVERRUN only by reset.
REQ-024 SHALL increment FRAMES_SENT by 1 on each accepted TLAST beat.
REQ-025 SHALL hold RESULT_BRAM_RENABLE low and RESULT_BRAM_ADDR_READ at last value when no read issued.

Reset
REQ-026 SHALL, with M_AXIS_ARESET high at a clock edge, force state IDLE, TVALID 0, TLAST 0, TDATA 0, RENABLE 0, ADDR_READ 0, FIFO empty, in-flight cleared, pending 0, OVERRUN 0, FRAMES_SENT 0, BUSY 0 in the next cycle.
REQ-027 SHALL abandon any mid-frame transfer on reset; BRAM data returning in the cycle after reset SHALL be discarded.
REQ-028 SHALL ignore FRAME_READY in a cycle where reset is high.

Structure
REQ-029 SHALL place state enumeration, NUMBER_OF_WORDS default and FIFO depth constant (2) in a shared package accum_stream_pkg.
REQ-030 SHALL implement the 2-entry FIFO as sub-module result_skid_buffer (push, pop, data, occupancy).

Verification
REQ-031 SHALL cover: BRAM word i = i, TREADY=1, one FRAME_READY -> 1024 consecutive beats, TDATA 0..1023, TLAST only on 1023, FRAMES_SENT=1, first TVALID 3 cycles after pulse.
REQ-032 SHALL cover: random TREADY (50%) -> TDATA sequence 0..1023 without loss or duplication, data stable during every stall.
REQ-033 SHALL cover: TREADY=0 permanently after FRAME_READY -> exactly 2 reads issued (addr 0,1), TVALID high, TDATA=0 held.
REQ-034 SHALL cover: second FRAME_READY at beat 500 -> second frame follows first TLAST, OVERRUN=0; third pulse at beat 600 -> OVERRUN=1, FRAMES_SENT=2 at end.
REQ-035 SHALL cover: reset at beat 300 -> next cycle TVALID=0, BUSY=0, FRAMES_SENT=0; new FRAME_READY restarts at addr 0 with TDATA 0..1023.
